// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard controller: stall-cause codes
// and the priority encoder that picks one cause when several are active.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_LOAD   = 2'b01,
    CAUSE_BRANCH = 2'b10,
    CAUSE_MDU    = 2'b11
  } stall_cause_e;

  // Load outranks branch-data, which outranks MDU.
  function automatic stall_cause_e pick_cause(input logic load_c,
                                              input logic branch_c,
                                              input logic mdu_c);
    stall_cause_e c;
    c = CAUSE_NONE;
    if (load_c) begin
      c = CAUSE_LOAD;
    end else if (branch_c) begin
      c = CAUSE_BRANCH;
    end else if (mdu_c) begin
      c = CAUSE_MDU;
    end
    return c;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter used to time multi-cycle hazards. A load is accepted
// only while the count is zero; a nonzero count decrements and stops at zero.
module wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_busy,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end else if (i_load) begin
      cnt <= i_value;
    end
  end

  always_comb begin
    o_busy = (cnt != '0);
    o_zero = (cnt == '0);
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller with multi-cycle load and MUL/DIV waits.
// Stall, bubble and flush are combinational from the ID/EX/MEM view plus two wait counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_rs_id,
  input  logic [REG_AW-1:0] i_rt_id,
  input  logic              i_use_rs_id,
  input  logic              i_use_rt_id,
  input  logic              i_branch_id,
  input  logic              i_branch_taken_id,
  input  logic              i_jump_id,
  input  logic              i_mdu_op_id,
  input  logic              i_hilo_use_id,
  input  logic              i_mem_read_ex,
  input  logic              i_reg_write_ex,
  input  logic [REG_AW-1:0] i_wr_reg_ex,
  input  logic              i_mem_read_mem,
  input  logic [REG_AW-1:0] i_wr_reg_mem,
  input  logic              i_mdu_start_ex,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_flush,
  output logic              o_mdu_busy,
  output logic [1:0]        o_stall_cause
);

  // Detect cycle counts as one stall cycle, so the counter holds the remainder.
  localparam logic [CNT_W-1:0] LD_CNT_NORM  = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] LD_CNT_BR    = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] MDU_CNT_INIT = CNT_W'(MDU_LAT - 1);

  logic             hit_ex;
  logic             hit_mem;
  logic             load_use;
  logic             branch_alu;
  logic             branch_mem;
  logic             mdu_wait;
  logic             stall_int;
  logic             ld_busy;
  logic             ld_zero;
  logic             mdu_busy;
  logic             mdu_zero;
  logic             ld_load;
  logic             mdu_load;
  logic [CNT_W-1:0] ld_value;
  stall_cause_e     cause;

  // Source-operand matching; register 0 never matches.
  always_comb begin
    hit_ex  = (i_wr_reg_ex != '0) &&
              ((i_use_rs_id && (i_rs_id == i_wr_reg_ex)) ||
               (i_use_rt_id && (i_rt_id == i_wr_reg_ex)));
    hit_mem = (i_wr_reg_mem != '0) &&
              ((i_use_rs_id && (i_rs_id == i_wr_reg_mem)) ||
               (i_use_rt_id && (i_rt_id == i_wr_reg_mem)));
  end

  always_comb begin
    load_use   = i_mem_read_ex && hit_ex && ld_zero;
    branch_alu = i_branch_id && i_reg_write_ex && !i_mem_read_ex && hit_ex;
    branch_mem = i_branch_id && i_mem_read_mem && hit_mem && ld_zero;
    mdu_wait   = (i_hilo_use_id || i_mdu_op_id) && mdu_busy;
    stall_int  = load_use || ld_busy || branch_alu || branch_mem || mdu_wait;
    cause      = pick_cause(load_use || ld_busy, branch_alu || branch_mem, mdu_wait);
  end

  // A branch consuming a load needs one extra cycle to compare in ID.
  always_comb begin
    ld_load  = load_use || branch_mem;
    ld_value = LD_CNT_NORM;
    if (load_use && i_branch_id) begin
      ld_value = LD_CNT_BR;
    end
    mdu_load = i_mdu_start_ex && !stall_int && mdu_zero;
  end

  wait_counter #(
    .CNT_W (CNT_W)
  ) u_ld_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ld_load),
    .i_value (ld_value),
    .o_busy  (ld_busy),
    .o_zero  (ld_zero)
  );

  wait_counter #(
    .CNT_W (CNT_W)
  ) u_mdu_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (mdu_load),
    .i_value (MDU_CNT_INIT),
    .o_busy  (mdu_busy),
    .o_zero  (mdu_zero)
  );

  // Outputs are forced low while reset is held.
  always_comb begin
    o_stall       = 1'b0;
    o_bubble      = 1'b0;
    o_flush       = 1'b0;
    o_mdu_busy    = 1'b0;
    o_stall_cause = CAUSE_NONE;
    if (!i_rst) begin
      o_stall       = stall_int;
      o_bubble      = stall_int;
      o_flush       = (i_jump_id || i_branch_taken_id) && !stall_int;
      o_mdu_busy    = mdu_busy;
      o_stall_cause = cause;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: three parameterisations share one stimulus stream and
// are checked every cycle against a deadline-based model plus directed literal checks.
module tb_hazard_ctrl_mc;

  localparam int unsigned N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_id, rt_id, wr_reg_ex, wr_reg_mem;
  logic       use_rs_id, use_rt_id, branch_id, branch_taken_id, jump_id;
  logic       mdu_op_id, hilo_use_id, mem_read_ex, reg_write_ex, mem_read_mem, mdu_start_ex;

  logic       st [N];
  logic       bb [N];
  logic       fl [N];
  logic       mb [N];
  logic [1:0] cs [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  // Model state: first cycle at which each wait is over.
  int ld_until  [N];
  int mdu_until [N];

  always #5 clk = ~clk;

  function automatic int mem_lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  function automatic int mdu_lat_of(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_ctrl_mc #(
      .REG_AW  (5),
      .MEM_LAT ((g == 0) ? 1 : (g == 1) ? 3 : 2),
      .MDU_LAT ((g == 2) ? 1 : 4),
      .CNT_W   (4)
    ) u_dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_rs_id           (rs_id),
      .i_rt_id           (rt_id),
      .i_use_rs_id       (use_rs_id),
      .i_use_rt_id       (use_rt_id),
      .i_branch_id       (branch_id),
      .i_branch_taken_id (branch_taken_id),
      .i_jump_id         (jump_id),
      .i_mdu_op_id       (mdu_op_id),
      .i_hilo_use_id     (hilo_use_id),
      .i_mem_read_ex     (mem_read_ex),
      .i_reg_write_ex    (reg_write_ex),
      .i_wr_reg_ex       (wr_reg_ex),
      .i_mem_read_mem    (mem_read_mem),
      .i_wr_reg_mem      (wr_reg_mem),
      .i_mdu_start_ex    (mdu_start_ex),
      .o_stall           (st[g]),
      .o_bubble          (bb[g]),
      .o_flush           (fl[g]),
      .o_mdu_busy        (mb[g]),
      .o_stall_cause     (cs[g])
    );
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h want %0h", name, k, cyc, act, exp);
    end
  endtask

  function automatic bit hit(input logic u, input logic [4:0] r, input logic [4:0] x);
    return u && (r == x) && (x != 5'd0);
  endfunction

  // Per-cycle comparison against the model, then advance the model past the next edge.
  always @(negedge clk) begin
    if (rst) armed = 1'b1;
    if (armed) begin
      for (int k = 0; k < N; k++) begin
        bit ldw, mbusy, mex, mmem, lu, ba, bm, ms, e_st, e_fl, e_mb;
        logic [1:0] e_cs;
        ldw   = cyc < ld_until[k];
        mbusy = cyc < mdu_until[k];
        mex   = hit(use_rs_id, rs_id, wr_reg_ex)  || hit(use_rt_id, rt_id, wr_reg_ex);
        mmem  = hit(use_rs_id, rs_id, wr_reg_mem) || hit(use_rt_id, rt_id, wr_reg_mem);
        lu    = mem_read_ex && mex && !ldw;
        ba    = branch_id && reg_write_ex && !mem_read_ex && mex;
        bm    = branch_id && mem_read_mem && mmem && !ldw;
        ms    = (hilo_use_id || mdu_op_id) && mbusy;
        e_st  = !rst && (lu || ldw || ba || bm || ms);
        e_fl  = !rst && (jump_id || branch_taken_id) && !e_st;
        e_mb  = !rst && mbusy;
        if (rst)            e_cs = 2'd0;
        else if (lu || ldw) e_cs = 2'd1;
        else if (ba || bm)  e_cs = 2'd2;
        else if (ms)        e_cs = 2'd3;
        else                e_cs = 2'd0;
        check("stall",  k, 32'(st[k]), 32'(e_st));
        check("bubble", k, 32'(bb[k]), 32'(e_st));
        check("flush",  k, 32'(fl[k]), 32'(e_fl));
        check("busy",   k, 32'(mb[k]), 32'(e_mb));
        check("cause",  k, 32'(cs[k]), 32'(e_cs));
        if (rst) begin
          ld_until[k]  = 0;
          mdu_until[k] = 0;
        end else begin
          if (lu)      ld_until[k] = cyc + mem_lat_of(k) + (branch_id ? 1 : 0);
          else if (bm) ld_until[k] = cyc + mem_lat_of(k);
          if (mdu_start_ex && !e_st && !mbusy) mdu_until[k] = cyc + mdu_lat_of(k);
        end
      end
    end
    cyc++;
  end

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; wr_reg_ex = 5'd0; wr_reg_mem = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; branch_id = 1'b0; branch_taken_id = 1'b0;
    jump_id = 1'b0; mdu_op_id = 1'b0; hilo_use_id = 1'b0; mem_read_ex = 1'b0;
    reg_write_ex = 1'b0; mem_read_mem = 1'b0; mdu_start_ex = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n [N];
    for (int k = 0; k < N; k++) begin
      ld_until[k]  = 0;
      mdu_until[k] = 0;
    end
    idle();
    rst = 1'b1;
    repeat (3) tick();

    // Reset masks a live load-use and jump.
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; wr_reg_ex = 5'd5;
    use_rs_id = 1'b1; rs_id = 5'd5; jump_id = 1'b1;
    #2;
    for (int k = 0; k < N; k++) begin
      check("rst_stall", k, 32'(st[k]), 32'd0);
      check("rst_flush", k, 32'(fl[k]), 32'd0);
    end
    tick();
    idle();
    rst = 1'b0;
    tick();

    // Load-use on $5, plain consumer then branch consumer.
    for (int br = 0; br < 2; br++) begin
      for (int k = 0; k < N; k++) n[k] = 0;
      for (int i = 0; i < 8; i++) begin
        idle();
        use_rs_id = 1'b1; rs_id = 5'd5; branch_id = (br == 1);
        if (i == 0) begin mem_read_ex = 1'b1; reg_write_ex = 1'b1; wr_reg_ex = 5'd5; end
        if (i == 1) begin mem_read_mem = 1'b1; wr_reg_mem = 5'd5; end
        #2;
        if (i == 0) begin
          check("lu_cause", 0, 32'(cs[0]), 32'd1);
          check("lu_flush", 0, 32'(fl[0]), 32'd0);
        end
        for (int k = 0; k < N; k++) n[k] += int'(st[k]);
        tick();
      end
      check("lu_len", 0, 32'(n[0]), 32'(1 + br));
      check("lu_len", 1, 32'(n[1]), 32'(3 + br));
      check("lu_len", 2, 32'(n[2]), 32'(2 + br));
    end

    // beq on $7 behind an ALU writer of $7, resolved taken.
    idle();
    branch_id = 1'b1; branch_taken_id = 1'b1; use_rs_id = 1'b1; rs_id = 5'd7;
    reg_write_ex = 1'b1; wr_reg_ex = 5'd7;
    #2;
    for (int k = 0; k < N; k++) begin
      check("br_stall", k, 32'(st[k]), 32'd1);
      check("br_cause", k, 32'(cs[k]), 32'd2);
      check("br_noflush", k, 32'(fl[k]), 32'd0);
    end
    tick();
    reg_write_ex = 1'b0; wr_reg_ex = 5'd0; wr_reg_mem = 5'd7;
    #2;
    check("br_release", 0, 32'(st[0]), 32'd0);
    check("br_flush", 0, 32'(fl[0]), 32'd1);
    tick();
    idle();
    #2;
    check("br_flush_once", 0, 32'(fl[0]), 32'd0);
    tick();

    // Register 0 never produces a hazard.
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; wr_reg_ex = 5'd0;
    use_rs_id = 1'b1; use_rt_id = 1'b1; branch_id = 1'b1;
    #2;
    check("r0_ex", 1, 32'(st[1]), 32'd0);
    tick();
    mem_read_ex = 1'b0; reg_write_ex = 1'b0; mem_read_mem = 1'b1;
    #2;
    check("r0_mem", 1, 32'(st[1]), 32'd0);
    tick();
    idle();

    // mult in EX then mflo held in ID.
    mdu_start_ex = 1'b1;
    #2;
    check("mdu_start_stall", 0, 32'(st[0]), 32'd0);
    tick();
    idle();
    hilo_use_id = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #2;
      check("mdu_busy", 0, 32'(mb[0]), (i < 4) ? 32'd1 : 32'd0);
      check("mdu_stall", 1, 32'(st[1]), (i < 4) ? 32'd1 : 32'd0);
      check("mdu_cause", 0, 32'(cs[0]), (i < 4) ? 32'd3 : 32'd0);
      check("mdu_lat1", 2, 32'(mb[2]), 32'd0);
      tick();
    end
    idle();
    mdu_start_ex = 1'b1;
    tick();
    idle();
    repeat (3) tick();
    hilo_use_id = 1'b1;
    #2;
    check("mflo_late", 0, 32'(st[0]), 32'd0);
    tick();
    idle();

    // Reset during the second cycle of a MEM_LAT=3 stall with MDU busy.
    mdu_start_ex = 1'b1;
    tick();
    idle();
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; wr_reg_ex = 5'd5; use_rs_id = 1'b1; rs_id = 5'd5;
    #2;
    check("rs_pre_stall", 1, 32'(st[1]), 32'd1);
    tick();
    idle();
    use_rs_id = 1'b1; rs_id = 5'd5; mem_read_mem = 1'b1; wr_reg_mem = 5'd5; jump_id = 1'b1;
    rst = 1'b1;
    #2;
    for (int k = 0; k < N; k++) begin
      check("rs_mid_stall", k, 32'(st[k]), 32'd0);
      check("rs_mid_busy",  k, 32'(mb[k]), 32'd0);
      check("rs_mid_flush", k, 32'(fl[k]), 32'd0);
      check("rs_mid_cause", k, 32'(cs[k]), 32'd0);
    end
    tick();
    rst = 1'b0;
    idle();
    use_rs_id = 1'b1; rs_id = 5'd5; hilo_use_id = 1'b1;
    #2;
    check("rs_after_stall", 1, 32'(st[1]), 32'd0);
    check("rs_after_busy",  1, 32'(mb[1]), 32'd0);
    tick();

    // Randomised traffic over a small register set to provoke overlaps.
    repeat (4000) begin
      rst             = ($urandom_range(0, 99) == 0);
      rs_id           = 5'($urandom_range(0, 3));
      rt_id           = 5'($urandom_range(0, 3));
      wr_reg_ex       = 5'($urandom_range(0, 3));
      wr_reg_mem      = 5'($urandom_range(0, 3));
      use_rs_id       = 1'($urandom_range(0, 1));
      use_rt_id       = 1'($urandom_range(0, 1));
      branch_id       = ($urandom_range(0, 3) == 0);
      branch_taken_id = branch_id && ($urandom_range(0, 1) == 1);
      jump_id         = ($urandom_range(0, 7) == 0);
      mdu_op_id       = ($urandom_range(0, 7) == 0);
      hilo_use_id     = ($urandom_range(0, 3) == 0);
      mem_read_ex     = ($urandom_range(0, 3) == 0);
      reg_write_ex    = mem_read_ex || ($urandom_range(0, 1) == 1);
      mem_read_mem    = ($urandom_range(0, 3) == 0);
      mdu_start_ex    = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
